// File: rtl/matmul_pkg.sv
// Shared constants and types for the matmul accelerator's APB register map.
// Register offsets occupy paddr[4:0]; scratchpad element indices sit above them.
package matmul_pkg;

  localparam int BUS_WIDTH  = 32;
  localparam int ADDR_WIDTH = 16;
  localparam int MAX_DIM    = 4;

  localparam logic [4:0] CONTROL   = 5'b00000;
  localparam logic [4:0] OPERAND_A = 5'b00100;
  localparam logic [4:0] OPERAND_B = 5'b01000;
  localparam logic [4:0] FLAGS     = 5'b01100;
  localparam logic [4:0] SP        = 5'b10000;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} apb_state_e;

endpackage

// File: rtl/apb_read_master.sv
// One-transfer APB read engine with wait-state timeout; a req seen together with
// ack chains the next transfer straight into SETUP with no idle cycle.
module apb_read_master #(
  parameter int BUS_WIDTH  = matmul_pkg::BUS_WIDTH,
  parameter int ADDR_WIDTH = matmul_pkg::ADDR_WIDTH,
  parameter int TIMEOUT    = 255
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   req_i,
  input  logic [ADDR_WIDTH-1:0]  addr_i,
  output logic                   ack_o,
  output logic                   timeout_o,
  output logic                   err_o,
  output logic [BUS_WIDTH-1:0]   rdata_o,
  output matmul_pkg::apb_state_e state_o,
  output logic                   psel_o,
  output logic                   penable_o,
  output logic [ADDR_WIDTH-1:0]  paddr_o,
  input  logic [BUS_WIDTH-1:0]   prdata_i,
  input  logic                   pready_i,
  input  logic                   pslverr_i
);
  import matmul_pkg::*;

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  apb_state_e    state;
  logic [CW-1:0] wait_cnt;
  logic          wait_expired;

  // Handshake: req_i/addr_i are only taken in IDLE or on the ack cycle; ack_o is
  // high for exactly one cycle per completed transfer and rdata_o/err_o are valid with it.
  assign wait_expired = (wait_cnt == CW'(TIMEOUT - 1));
  assign ack_o        = (state == ACCESS) && pready_i;
  assign timeout_o    = (state == ACCESS) && !pready_i && wait_expired;
  assign err_o        = ack_o && pslverr_i;
  assign rdata_o      = prdata_i;
  assign state_o      = state;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= IDLE;
      psel_o    <= 1'b0;
      penable_o <= 1'b0;
      paddr_o   <= '0;
      wait_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_i) begin
            state     <= SETUP;
            psel_o    <= 1'b1;
            penable_o <= 1'b0;
            paddr_o   <= addr_i;
          end
        end
        SETUP: begin
          state     <= ACCESS;
          penable_o <= 1'b1;
          wait_cnt  <= '0;
        end
        ACCESS: begin
          if (pready_i) begin
            if (req_i) begin
              state     <= SETUP;
              penable_o <= 1'b0;
              paddr_o   <= addr_i;
            end else begin
              state     <= DONE;
              psel_o    <= 1'b0;
              penable_o <= 1'b0;
            end
          end else if (wait_expired) begin
            state     <= DONE;
            psel_o    <= 1'b0;
            penable_o <= 1'b0;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/matmul_sp_reader.sv
// Drains FLAGS and a row-major C matrix from one scratchpad over APB into flat
// result vectors; state_o exposes the APB engine FSM for debug.
module matmul_sp_reader #(
  parameter int BUS_WIDTH   = matmul_pkg::BUS_WIDTH,
  parameter int ADDR_WIDTH  = matmul_pkg::ADDR_WIDTH,
  parameter int MAX_DIM     = matmul_pkg::MAX_DIM,
  parameter int SP_NTARGETS = 4,
  parameter int TIMEOUT     = 255
) (
  input  logic                                    clk_i,
  input  logic                                    rst_i,
  input  logic                                    start_i,
  input  logic [$clog2(MAX_DIM+1)-1:0]            rows_i,
  input  logic [$clog2(MAX_DIM+1)-1:0]            cols_i,
  input  logic [$clog2(SP_NTARGETS)-1:0]          sp_sel_i,
  output logic                                    psel_o,
  output logic                                    penable_o,
  output logic                                    pwrite_o,
  output logic [ADDR_WIDTH-1:0]                   paddr_o,
  input  logic [BUS_WIDTH-1:0]                    prdata_i,
  input  logic                                    pready_i,
  input  logic                                    pslverr_i,
  output logic                                    busy_o,
  output logic                                    done_o,
  output logic                                    err_o,
  output logic [BUS_WIDTH-1:0]                    flags_o,
  output logic [BUS_WIDTH*MAX_DIM*MAX_DIM-1:0]    data_sp_o,
  output matmul_pkg::apb_state_e                  state_o
);
  import matmul_pkg::*;

  localparam int DW    = $clog2(MAX_DIM + 1);
  localparam int SW    = $clog2(SP_NTARGETS);
  localparam int SLOTW = $clog2(BUS_WIDTH * MAX_DIM * MAX_DIM);

  logic [DW-1:0]         rows_q, cols_q, i_q, j_q, ni, nj;
  logic [SW-1:0]         sel_q;
  logic                  on_flags, accept, more, req, ack, timeout, slverr;
  logic [ADDR_WIDTH-1:0] next_addr;
  logic [ADDR_WIDTH-6:0] elem_idx;
  logic [BUS_WIDTH-1:0]  rdata;
  logic [SLOTW-1:0]      slot_base;

  function automatic logic [DW-1:0] sat_dim(input logic [DW-1:0] d);
    return (32'(d) > 32'(MAX_DIM)) ? DW'(MAX_DIM) : d;
  endfunction

  assign pwrite_o  = 1'b0;
  assign accept    = start_i && !busy_o;
  assign elem_idx  = (ADDR_WIDTH-5)'(32'(sel_q) * 32'(MAX_DIM * MAX_DIM)
                                     + 32'(ni) * 32'(MAX_DIM) + 32'(nj));
  assign slot_base = SLOTW'((32'(i_q) * 32'(MAX_DIM) + 32'(j_q)) * 32'(BUS_WIDTH));

  // Next element in row-major order; the FLAGS read is followed by (0,0) only if C is non-empty.
  always_comb begin
    more      = 1'b0;
    ni        = '0;
    nj        = '0;
    req       = 1'b0;
    next_addr = '0;
    if (on_flags) begin
      more = (rows_q != '0) && (cols_q != '0);
    end else if (j_q + DW'(1) < cols_q) begin
      more = 1'b1;
      ni   = i_q;
      nj   = j_q + DW'(1);
    end else if (i_q + DW'(1) < rows_q) begin
      more = 1'b1;
      ni   = i_q + DW'(1);
    end
    if (accept) begin
      req       = 1'b1;
      next_addr = {(ADDR_WIDTH-5)'(0), FLAGS};
    end else if (ack && more) begin
      req       = 1'b1;
      next_addr = {elem_idx, SP};
    end
  end

  apb_read_master #(
    .BUS_WIDTH (BUS_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH),
    .TIMEOUT   (TIMEOUT)
  ) u_apb (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .req_i    (req),
    .addr_i   (next_addr),
    .ack_o    (ack),
    .timeout_o(timeout),
    .err_o    (slverr),
    .rdata_o  (rdata),
    .state_o  (state_o),
    .psel_o   (psel_o),
    .penable_o(penable_o),
    .paddr_o  (paddr_o),
    .prdata_i (prdata_i),
    .pready_i (pready_i),
    .pslverr_i(pslverr_i)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
      err_o     <= 1'b0;
      flags_o   <= '0;
      data_sp_o <= '0;
      rows_q    <= '0;
      cols_q    <= '0;
      sel_q     <= '0;
      i_q       <= '0;
      j_q       <= '0;
      on_flags  <= 1'b0;
    end else begin
      done_o <= 1'b0;
      if (accept) begin
        busy_o    <= 1'b1;
        err_o     <= 1'b0;
        flags_o   <= '0;
        data_sp_o <= '0;
        rows_q    <= sat_dim(rows_i);
        cols_q    <= sat_dim(cols_i);
        sel_q     <= sp_sel_i;
        i_q       <= '0;
        j_q       <= '0;
        on_flags  <= 1'b1;
      end else begin
        if (ack) begin
          if (on_flags) flags_o <= rdata;
          else          data_sp_o[slot_base +: BUS_WIDTH] <= rdata;
          if (slverr) err_o <= 1'b1;
          if (more) begin
            on_flags <= 1'b0;
            i_q      <= ni;
            j_q      <= nj;
          end else begin
            done_o <= 1'b1;
          end
        end
        // A timed-out transfer stores nothing and ends the whole sequence.
        if (timeout) begin
          err_o  <= 1'b1;
          done_o <= 1'b1;
        end
        if (done_o) busy_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_matmul_sp_reader.sv
// Bench for matmul_sp_reader: APB slave model with random wait states, a table of
// directed reads, random reads against a row-major reference, timeout and reset sequences.
module tb_matmul_sp_reader;

  localparam int BW  = 32;
  localparam int MD  = 4;
  localparam int DWD = BW * MD * MD;

  logic            clk_i = 1'b0;
  logic            rst_i = 1'b1;
  logic            start_i = 1'b0;
  logic [2:0]      rows_i = '0;
  logic [2:0]      cols_i = '0;
  logic [1:0]      sp_sel_i = '0;
  logic            psel_o, penable_o, pwrite_o;
  logic [15:0]     paddr_o;
  logic [BW-1:0]   prdata_i = '0;
  logic            pready_i = 1'b0;
  logic            pslverr_i = 1'b0;
  logic            busy_o, done_o, err_o;
  logic [BW-1:0]   flags_o;
  logic [DWD-1:0]  data_sp_o;
  matmul_pkg::apb_state_e state_o;

  matmul_sp_reader dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
    .rows_i(rows_i), .cols_i(cols_i), .sp_sel_i(sp_sel_i),
    .psel_o(psel_o), .penable_o(penable_o), .pwrite_o(pwrite_o), .paddr_o(paddr_o),
    .prdata_i(prdata_i), .pready_i(pready_i), .pslverr_i(pslverr_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .flags_o(flags_o), .data_sp_o(data_sp_o), .state_o(state_o)
  );

  always #5 clk_i = ~clk_i;

  // ---------------- environment: APB slave memory ----------------
  logic [BW-1:0] elem_mem [0:63];
  logic [BW-1:0] flags_val;
  logic [15:0]   err_paddr;
  int            wait_min, wait_max;
  bit            hang;

  // written only by the slave process
  logic [15:0]   addr_log[$];
  int            wait_total = 0;
  int            unstable_cnt = 0;
  int            wait_left = 0;
  logic [15:0]   setup_addr = '0;

  function automatic logic [BW-1:0] read_mem(input logic [15:0] a);
    if (a[4:0] == 5'b01100) return flags_val;
    if (a[4:0] == 5'b10000 && a[15:5] < 11'd64) return elem_mem[a[10:5]];
    return 32'hDEAD_BEEF;
  endfunction

  always @(negedge clk_i) begin
    if (psel_o === 1'b1 && penable_o === 1'b0) begin
      wait_left  = int'($urandom_range(wait_max, wait_min));
      setup_addr = paddr_o;
      pready_i   = 1'b0;
      pslverr_i  = 1'b0;
    end else if (psel_o === 1'b1 && penable_o === 1'b1) begin
      if (paddr_o !== setup_addr) unstable_cnt++;
      if (hang) begin
        pready_i = 1'b0;
      end else if (wait_left > 0) begin
        pready_i = 1'b0;
        wait_left--;
        wait_total++;
      end else begin
        pready_i  = 1'b1;
        prdata_i  = read_mem(paddr_o);
        pslverr_i = (paddr_o == err_paddr);
        addr_log.push_back(paddr_o);
      end
    end else begin
      pready_i  = 1'b0;
      pslverr_i = 1'b0;
    end
  end

  // ---------------- scoreboard helpers ----------------
  int n_checks = 0;
  int n_errors = 0;

  function automatic void chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic void chkw(input string name, input logic [DWD-1:0] act, input logic [DWD-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic logic [15:0] elem_addr(input int sel, input int i, input int j);
    return 16'(((sel * 16 + i * 4 + j) << 5) | 16);
  endfunction

  // ---------------- driver + reference model for one readback ----------------
  task automatic do_read(input int rows, input int cols, input int sel, input int wmin,
                         input int wmax, input int err_slot, input bit preset,
                         input int exp_n, input string tag);
    int              rs, cs, cyc, log_base, wait_base, unst_base;
    logic [DWD-1:0]  exp_data;
    logic            exp_err;
    logic [15:0]     exp_q[$];
    logic [15:0]     got;

    rs = (rows > MD) ? MD : rows;
    cs = (cols > MD) ? MD : cols;
    if (exp_n < 0) exp_n = 1 + rs * cs;

    flags_val = $urandom();
    for (int k = 0; k < 64; k++) elem_mem[k] = $urandom();
    if (preset) begin
      flags_val              = 32'h5;
      elem_mem[sel * 16 + 0] = 32'd1;
      elem_mem[sel * 16 + 1] = 32'hFFFF_FFFE;
      elem_mem[sel * 16 + 4] = 32'd3;
      elem_mem[sel * 16 + 5] = 32'd4;
    end
    err_paddr = (err_slot >= 0) ? 16'(((sel * 16 + err_slot) << 5) | 16) : 16'hFFFF;
    wait_min  = wmin;
    wait_max  = wmax;
    hang      = 1'b0;

    exp_q.push_back(16'h000C);
    exp_data = '0;
    exp_err  = 1'b0;
    for (int i = 0; i < rs; i++) begin
      for (int j = 0; j < cs; j++) begin
        exp_q.push_back(elem_addr(sel, i, j));
        exp_data[(i * MD + j) * BW +: BW] = elem_mem[sel * 16 + i * 4 + j];
        if (err_slot == i * 4 + j) exp_err = 1'b1;
      end
    end

    @(posedge clk_i); #1;
    log_base  = addr_log.size();
    wait_base = wait_total;
    unst_base = unstable_cnt;
    rows_i = 3'(rows); cols_i = 3'(cols); sp_sel_i = 2'(sel); start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    cyc = 1;
    chk32({tag, " busy_at_accept"}, 32'(busy_o), 32'd1);
    chk32({tag, " err_cleared"}, 32'(err_o), 32'd0);
    chk32({tag, " flags_cleared"}, flags_o, 32'd0);
    chkw({tag, " data_cleared"}, data_sp_o, '0);

    while (done_o !== 1'b1 && cyc < 700) begin
      @(posedge clk_i); #1;
      cyc++;
    end
    chk32({tag, " done_cycle"}, 32'(cyc), 32'(2 * exp_n + 1 + (wait_total - wait_base)));
    chk32({tag, " n_reads"}, 32'(addr_log.size() - log_base), 32'(exp_n));
    for (int k = 0; k < exp_q.size(); k++) begin
      got = (log_base + k < addr_log.size()) ? addr_log[log_base + k] : 16'hFFFF;
      chk32($sformatf("%s addr%0d", tag, k), 32'(got), 32'(exp_q[k]));
    end
    chk32({tag, " paddr_stable"}, 32'(unstable_cnt - unst_base), 32'd0);
    chk32({tag, " flags"}, flags_o, flags_val);
    chkw({tag, " data"}, data_sp_o, exp_data);
    chk32({tag, " err"}, 32'(err_o), 32'(exp_err));
    chk32({tag, " busy_at_done"}, 32'(busy_o), 32'd1);
    if (preset) chk32({tag, " elem01"}, data_sp_o[63:32], 32'hFFFF_FFFE);

    @(posedge clk_i); #1;
    chk32({tag, " done_pulse"}, 32'(done_o), 32'd0);
    chk32({tag, " busy_fall"}, 32'(busy_o), 32'd0);
    chkw({tag, " data_hold"}, data_sp_o, exp_data);
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    int rows; int cols; int sel; int wmin; int wmax; int err_slot; bit preset; int exp_n;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int cyc, log_base;
    bit saw_psel;

    vecs[0] = '{rows: 2, cols: 2, sel: 1, wmin: 0, wmax: 0, err_slot: -1, preset: 1, exp_n: 5};
    vecs[1] = '{rows: 4, cols: 4, sel: 0, wmin: 2, wmax: 2, err_slot: -1, preset: 0, exp_n: 17};
    vecs[2] = '{rows: 0, cols: 3, sel: 2, wmin: 0, wmax: 0, err_slot: -1, preset: 0, exp_n: 1};
    vecs[3] = '{rows: 3, cols: 3, sel: 3, wmin: 0, wmax: 1, err_slot: 4,  preset: 0, exp_n: 10};
    vecs[4] = '{rows: 7, cols: 2, sel: 1, wmin: 0, wmax: 2, err_slot: -1, preset: 0, exp_n: 9};
    vecs[5] = '{rows: 1, cols: 5, sel: 0, wmin: 1, wmax: 3, err_slot: 3,  preset: 0, exp_n: 5};
    vecs[6] = '{rows: 4, cols: 0, sel: 3, wmin: 0, wmax: 0, err_slot: 0,  preset: 0, exp_n: 1};

    wait_min = 0; wait_max = 0; hang = 1'b0; err_paddr = 16'hFFFF; flags_val = '0;
    for (int k = 0; k < 64; k++) elem_mem[k] = '0;

    // clock/reset
    rst_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    chk32("reset psel", 32'(psel_o), 32'd0);
    chk32("reset penable", 32'(penable_o), 32'd0);
    chk32("reset paddr", 32'(paddr_o), 32'd0);
    chk32("reset busy", 32'(busy_o), 32'd0);
    chk32("reset done", 32'(done_o), 32'd0);
    chk32("reset err", 32'(err_o), 32'd0);
    chk32("reset flags", flags_o, 32'd0);
    chkw("reset data", data_sp_o, '0);
    chk32("reset state", 32'(state_o), 32'(matmul_pkg::IDLE));
    rst_i = 1'b0;
    @(posedge clk_i); #1;

    for (int v = 0; v < 7; v++)
      do_read(vecs[v].rows, vecs[v].cols, vecs[v].sel, vecs[v].wmin, vecs[v].wmax,
              vecs[v].err_slot, vecs[v].preset, vecs[v].exp_n, $sformatf("vec%0d", v));

    // random sweep
    for (int r = 0; r < 12; r++)
      do_read(int'($urandom_range(7, 0)), int'($urandom_range(7, 0)), int'($urandom_range(3, 0)),
              0, int'($urandom_range(3, 0)),
              ($urandom_range(3, 0) == 0) ? int'($urandom_range(15, 0)) : -1,
              1'b0, -1, $sformatf("rnd%0d", r));

    // timeout: the slave never answers the FLAGS read
    hang = 1'b1;
    @(posedge clk_i); #1;
    log_base = addr_log.size();
    rows_i = 3'd2; cols_i = 3'd2; sp_sel_i = 2'd0; start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    cyc = 1;
    while (done_o !== 1'b1 && cyc < 400) begin
      @(posedge clk_i); #1;
      cyc++;
    end
    chk32("timeout done_cycle", 32'(cyc), 32'd257);
    chk32("timeout err", 32'(err_o), 32'd1);
    chk32("timeout psel", 32'(psel_o), 32'd0);
    chk32("timeout flags", flags_o, 32'd0);
    chk32("timeout n_reads", 32'(addr_log.size() - log_base), 32'd0);
    hang = 1'b0;
    @(posedge clk_i); #1;
    chk32("timeout busy_fall", 32'(busy_o), 32'd0);
    do_read(2, 2, 0, 0, 0, -1, 1'b0, 5, "after_timeout");

    // reset during ACCESS of the third transfer, with an ignored start while busy
    wait_min = 0; wait_max = 0; err_paddr = 16'hFFFF; flags_val = 32'hA5A5_0001;
    for (int k = 0; k < 64; k++) elem_mem[k] = $urandom();
    @(posedge clk_i); #1;
    rows_i = 3'd3; cols_i = 3'd3; sp_sel_i = 2'd2; start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    @(posedge clk_i); #1;
    @(posedge clk_i); #1;
    rows_i = 3'd1; cols_i = 3'd1; sp_sel_i = 2'd0; start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    @(posedge clk_i); #1;
    @(posedge clk_i); #1;
    chk32("rst_mid penable", 32'(penable_o), 32'd1);
    chk32("rst_mid paddr", 32'(paddr_o), 32'(elem_addr(2, 0, 1)));
    chk32("rst_mid pwrite", 32'(pwrite_o), 32'd0);
    chk32("rst_mid flags", flags_o, 32'hA5A5_0001);
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    chk32("rst_mid psel_after", 32'(psel_o), 32'd0);
    chk32("rst_mid penable_after", 32'(penable_o), 32'd0);
    chk32("rst_mid busy_after", 32'(busy_o), 32'd0);
    chk32("rst_mid flags_after", flags_o, 32'd0);
    chkw("rst_mid data_after", data_sp_o, '0);
    rst_i = 1'b0;
    log_base = addr_log.size();
    saw_psel = 1'b0;
    repeat (10) begin
      @(posedge clk_i); #1;
      if (psel_o !== 1'b0 || busy_o !== 1'b0 || done_o !== 1'b0) saw_psel = 1'b1;
    end
    chk32("rst_quiet", 32'(saw_psel), 32'd0);
    chk32("rst_quiet reads", 32'(addr_log.size() - log_base), 32'd0);
    do_read(3, 3, 2, 0, 1, -1, 1'b0, 10, "after_reset");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
